// File: rtl/accel_pkg.sv
// Shared accelerator types and default geometry for the tile buffer and its RAM.
// Pure definitions; no logic, no latency.
package accel_pkg;

  localparam int TILE_WIDTH_DEF = 256;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ELEM_COUNT_DEF = TILE_WIDTH_DEF / DATA_WIDTH_DEF;
  localparam int MAX_TILES_DEF  = 32;

  typedef logic [ELEM_COUNT_DEF-1:0][DATA_WIDTH_DEF-1:0] tile_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILLING,
    ST_LOADED,
    ST_DRAINING
  } tbuf_state_e;

endpackage

// File: rtl/tile_ram.sv
// Tile storage: DEPTH x WIDTH flops, one synchronous write port, one combinational read port.
// Write lands at the clock edge; read is same-cycle; no flow control, contents are never reset.
module tile_ram #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/tile_buffer_v.sv
// Captures loader tiles, then replays them in order over valid/ready; contents survive drains.
// out_valid one cycle after start; out_data is registered and held while out_ready is low.
module tile_buffer_v
  import accel_pkg::*;
#(
  parameter int TILE_WIDTH = TILE_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_TILES  = MAX_TILES_DEF,
  localparam int ELEM_COUNT = TILE_WIDTH / DATA_WIDTH,
  localparam int AW         = $clog2(MAX_TILES),
  localparam int CW         = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tile_in,
  input  logic [DATA_WIDTH-1:0] data_in [ELEM_COUNT],
  input  logic                  load_done,
  input  logic                  clear,
  input  logic                  start,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data [ELEM_COUNT],
  output logic                  out_last,
  output logic                  loaded,
  output logic [CW-1:0]         tile_count,
  output logic                  overflow,
  output logic                  proto_err
);

  if (DATA_WIDTH != 8) begin : g_bad_dw
    $fatal(1, "tile_buffer_v: DATA_WIDTH must be 8");
  end
  if ((TILE_WIDTH % 8) != 0) begin : g_bad_tw
    $fatal(1, "tile_buffer_v: TILE_WIDTH must be a multiple of 8");
  end
  if (MAX_TILES < 2 || (MAX_TILES & (MAX_TILES - 1)) != 0) begin : g_bad_mt
    $fatal(1, "tile_buffer_v: MAX_TILES must be a power of two >= 2");
  end

  tbuf_state_e           state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  ovf_q, ovf_d;
  logic                  perr_q, perr_d;
  logic [TILE_WIDTH-1:0] out_data_q;

  logic                  we;
  logic                  load_out;
  logic [AW-1:0]         raddr;
  logic [TILE_WIDTH-1:0] wdata;
  logic [TILE_WIDTH-1:0] rdata;
  logic                  is_last;

  for (genvar e = 0; e < ELEM_COUNT; e++) begin : g_elem
    assign wdata[e*DATA_WIDTH +: DATA_WIDTH] = data_in[e];
    assign out_data[e] = out_data_q[e*DATA_WIDTH +: DATA_WIDTH];
  end

  tile_ram #(
    .WIDTH (TILE_WIDTH),
    .DEPTH (MAX_TILES)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (count_q[AW-1:0]),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign is_last = ({1'b0, rd_ptr_q} == (count_q - CW'(1)));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    perr_d   = perr_q;
    we       = 1'b0;
    load_out = 1'b0;
    raddr    = '0;
    if (clear) begin
      state_d = ST_EMPTY;
      count_d = '0;
      ovf_d   = 1'b0;
      perr_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (tile_in) begin
            we      = 1'b1;
            count_d = CW'(1);
            state_d = load_done ? ST_LOADED : ST_FILLING;
          end else if (load_done) begin
            state_d = ST_LOADED;
          end
        end
        ST_FILLING: begin
          // A coincident load_done still commits this cycle's tile first.
          if (tile_in) begin
            if (count_q == CW'(MAX_TILES)) begin
              ovf_d = 1'b1;
            end else begin
              we      = 1'b1;
              count_d = count_q + CW'(1);
            end
          end
          if (load_done) state_d = ST_LOADED;
        end
        ST_LOADED: begin
          if (tile_in) perr_d = 1'b1;
          if (start && count_q != '0) begin
            state_d  = ST_DRAINING;
            rd_ptr_d = '0;
            raddr    = '0;
            load_out = 1'b1;
          end
        end
        ST_DRAINING: begin
          if (tile_in) perr_d = 1'b1;
          if (out_ready) begin
            if (is_last) begin
              state_d = ST_LOADED;
            end else begin
              rd_ptr_d = rd_ptr_q + AW'(1);
              raddr    = rd_ptr_q + AW'(1);
              load_out = 1'b1;
            end
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
      perr_q     <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      perr_q   <= perr_d;
      if (load_out) out_data_q <= rdata;
    end
  end

  assign out_valid  = (state_q == ST_DRAINING);
  assign out_last   = out_valid && is_last;
  assign loaded     = (state_q == ST_LOADED);
  assign tile_count = count_q;
  assign overflow   = ovf_q;
  assign proto_err  = perr_q;

endmodule

// File: doc/tile_buffer_v.md
# tile_buffer_v

Tile-granular vector buffer directly downstream of the vector loader. Captures each tile the loader emits (a `tile_in` pulse with `ELEM_COUNT` parallel bytes), holds up to `MAX_TILES` tiles until the loader signals transfer end, then replays them in order to the compute datapath over a valid/ready stream. Contents persist across drains, so operands can be reused without reloading from DRAM.

## Interface
- `TILE_WIDTH`, 256: bits per tile; multiple of 8.
- `DATA_WIDTH`, 8: element width; any other value is a `$fatal` at elaboration.
- `MAX_TILES`, 32: buffer depth in tiles; power of two, ≥2.
- `ELEM_COUNT` (derived, localparam): `TILE_WIDTH/DATA_WIDTH`.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tile_in` in 1: one-cycle pulse; `data_in` holds a complete tile.
- `data_in` in `DATA_WIDTH` x `ELEM_COUNT` (unpacked): tile elements; element 0 is the lowest address.
- `load_done` in 1: one-cycle pulse; the loader transfer is complete.
- `clear` in 1: synchronous flush to empty.
- `start` in 1: one-cycle pulse; begin draining from tile 0.
- `out_valid` out 1: `out_data` holds a tile.
- `out_ready` in 1: consumer accepts.
- `out_data` out `DATA_WIDTH` x `ELEM_COUNT`: current tile, registered.
- `out_last` out 1: `out_data` holds the final stored tile.
- `loaded` out 1: high in LOADED state.
- `tile_count` out `$clog2(MAX_TILES)+1`: number of tiles stored.
- `overflow` out 1: sticky; a tile was dropped because the buffer was full.
- `proto_err` out 1: sticky; `tile_in` arrived while in LOADED or DRAINING.

## Operation
- States: EMPTY, FILLING, LOADED, DRAINING.
- **EMPTY**
  - `tile_count`=0.
  - `tile_in`: write entry 0, count←1, go to FILLING.
  - `load_done` alone: go to LOADED with count 0.
- **FILLING**
  - `tile_in`: write entry[count], count+1.
  - If count==MAX_TILES: tile dropped, `overflow`←1, count unchanged.
  - `load_done`: go to LOADED.
  - `tile_in` and `load_done` in the same cycle (the loader's last tile): store the tile first; LOADED then includes it.
- **LOADED**
  - `loaded`=1.
  - `start` with count>0: go to DRAINING, rd_ptr←0, `out_data`←entry 0.
  - `start` with count==0: ignored.
  - `tile_in`: dropped, `proto_err`←1.
  - `load_done`: ignored.
- **DRAINING**
  - `out_valid`=1.
  - `out_last`=(rd_ptr==count-1).
  - Handshake (`out_valid`&`out_ready`), not last: rd_ptr+1, `out_data`←next entry.
  - Handshake on the last tile: return to LOADED, `out_valid`←0. Contents are retained for a later `start`.
  - `out_data` is stable while `out_valid`&!`out_ready`.
  - `tile_in`: dropped, `proto_err`←1.
  - `start`: ignored.
- **`clear`** (any state, highest priority)
  - Next state EMPTY; count←0; `overflow`←0, `proto_err`←0; `out_valid`←0.
  - A `tile_in` in the same cycle is discarded.
  - Stored data is not zeroed.
- **Widths**
  - rd_ptr and write index are `$clog2(MAX_TILES)` bits.
  - count has one extra bit so that MAX_TILES is representable.

## Timing
- Reset values:
  - outputs: `out_valid`=0, `out_last`=0, `out_data`=0, `loaded`=0, `tile_count`=0, `overflow`=0, `proto_err`=0.
  - state: EMPTY.
  - Storage is not reset.
- A reset in mid-fill or mid-drain aborts immediately and asynchronously.
- `tile_in` at edge t: the tile is written at t; `tile_count` reflects it after t.
- `start` at edge t: `out_valid`=1 with entry 0 after t (1-cycle latency).
- Sustained `out_ready`=1: one tile per cycle, no bubbles. count N drains in N cycles after the first `out_valid`.
- `loaded` rises the cycle after `load_done`, and again the cycle after the last handshake.

## Structure
- Shared package `accel_pkg`:
  - `TILE_WIDTH`, `DATA_WIDTH`, `ELEM_COUNT` defaults;
  - `tile_t` (packed `ELEM_COUNT`x`DATA_WIDTH`);
  - `tbuf_state_e` enum.
- Sub-module `tile_ram`: `MAX_TILES` x `TILE_WIDTH` flop array, 1 write port and 1 combinational read port. The buffer registers the read data into `out_data`.
- FSM, counters and sticky flags live in `tile_buffer_v`.

## Test plan
- **Fill and drain:** 3 tiles (bytes `0x10+k`, `0x20+k`, `0x30+k`), `load_done` coincident with tile 3, `start`, `out_ready`=1 → `tile_count`=3; 3 consecutive `out_valid` beats in order; `out_last` only on beat 3; then `loaded`=1.
- **Backpressure:** drain 4 tiles with `out_ready` toggling 1,0,0,1,… → `out_data` held while stalled; exactly 4 handshakes; no duplicated or skipped tile.
- **Overflow:** `MAX_TILES`+2 `tile_in` pulses → `tile_count`=`MAX_TILES`; `overflow`=1; drain returns only the first `MAX_TILES` tiles.
- **Replay and protocol error:** second `start` after a complete drain → identical beat sequence. `tile_in` during the drain → `proto_err`=1 and output is unaffected.
- **Clear and empty:** `clear` mid-drain (beat 2 of 5) → `out_valid`=0 next cycle; state EMPTY; flags cleared. Then `load_done` with no tiles followed by `start` → `out_valid` stays 0.
- **Async reset:** `rst_n` low mid-fill, between clock edges → all outputs at reset values immediately; after release, a fresh fill of 1 tile works.
